// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of fetch_sequencer: the imem read port and the decode handshake.
// Decode handshake: a word transfers on a cycle with ins_valid & ins_ready; instr/instr_pc hold until then.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [15:0]       im_address;
    logic              im_select;
    logic [15:0]       im_data;
    logic              ins_valid;
    logic              ins_ready;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output im_address, im_select, ins_valid, instr, instr_pc,
        input  im_data, ins_ready
    );

    modport slave (
        input  im_address, im_select, ins_valid, instr, instr_pc,
        output im_data, ins_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner: strobes imem, captures the word after MEM_LAT cycles, offers it to decode.
// Optional FETCH_STAT_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_sequencer #(
    parameter int         ADDR_W  = 4,
    parameter int         MEM_LAT = 1,
    parameter logic [3:0] JMP_OP  = 4'b1110,
    parameter logic [3:0] JIZ_OP  = 4'b1111,
    parameter logic [3:0] HALT_OP = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              zero_flag,
    input  logic              zf_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        dbg_state,
`ifdef FETCH_STAT_EN
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt,
`endif
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        RESOLVE = 3'd4,
        HALTED  = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [2:0]        wait_cnt, cnt_n;
    logic              capture;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;

    assign opcode    = bus.instr[15:12];
    assign target    = bus.instr[ADDR_W-1:0];
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = wait_cnt;
        capture = 1'b0;
        // A redirect overrides whatever the active state would otherwise do this cycle.
        if (flush && state != IDLE && state != HALTED) begin
            state_n = REQ;
            pc_n    = flush_addr;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state_n = REQ;
                        pc_n    = '0;
                    end
                end
                REQ: begin
                    if (MEM_LAT == 0) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n   = 3'(MEM_LAT - 1);
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n = wait_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (bus.ins_ready) begin
                        if (opcode == JMP_OP) begin
                            pc_n    = target;
                            state_n = REQ;
                        end else if (opcode == JIZ_OP) begin
                            state_n = RESOLVE;
                        end else if (opcode == HALT_OP) begin
                            state_n = HALTED;
                        end else begin
                            pc_n    = pc + 1'b1;
                            state_n = REQ;
                        end
                    end
                end
                RESOLVE: begin
                    if (zf_valid) begin
                        pc_n    = zero_flag ? target : pc + 1'b1;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= '0;
            wait_cnt       <= 3'd0;
            bus.im_address <= 16'd0;
            bus.im_select  <= 1'b0;
            bus.instr      <= 16'd0;
            bus.instr_pc   <= '0;
            bus.ins_valid  <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            wait_cnt <= cnt_n;
            if (state_n == REQ) begin
                bus.im_address <= 16'(pc_n);
            end
            bus.im_select <= (state_n == REQ);
            if (capture) begin
                bus.instr    <= bus.im_data;
                bus.instr_pc <= pc;
            end
            bus.ins_valid <= (state_n == HOLD);
            busy          <= (state_n != IDLE) && (state_n != HALTED);
            halted        <= (state_n == HALTED);
        end
    end

`ifdef FETCH_STAT_EN
    logic accepted;
    logic stalled;

    assign accepted = (state == HOLD) && bus.ins_ready && !flush;
    assign stalled  = ((state == HOLD) && !bus.ins_ready) || ((state == RESOLVE) && !zf_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (accepted && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (stalled && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif
endmodule
